apb_master: RTL and testbench

- APB3 requester (initiator) that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers toward 8-bit-address/8-bit-data APB slaves on the same pclk.
- Returns read data and error status on a one-cycle response strobe.
- Provides an ACCESS-phase timeout so a stuck slave cannot hang the bus.
- Sits between the system-side command source and the peripheral APB bus.

---
 rtl/apb_master_if.sv | 48 ++++
 rtl/apb_master.sv | 145 ++++++++++++++
 tb/tb_apb_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// apb_master_if
//   Bundles the command/response handshake and the APB3 bus seen by
//   apb_master.
//   Command : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata
//   Response: rsp_valid, rsp_rdata, rsp_err, rsp_timeout
//   APB     : psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr
//   modport master : the requester (apb_master) view
//   modport slave  : the opposite view (command source + APB completer)
interface apb_master_if #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [DATAWIDTH-1:0] cmd_wdata;

  logic                 rsp_valid;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;

  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDRWIDTH-1:0] paddr;
  logic [DATAWIDTH-1:0] pwdata;
  logic [DATAWIDTH-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  prdata, pready, pslverr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output prdata, pready, pslverr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// apb_master
//   APB3 requester: turns a valid/ready command into one SETUP + ACCESS
//   transfer and reports completion on a one-cycle rsp_valid pulse.
//   An ACCESS-phase timeout aborts transfers to a stuck slave.
// Ports
//   pclk    : clock, rising edge
//   presetn : synchronous active-low reset
//   bus     : apb_master_if.master (command, response and APB signals)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; cmd_ready=1, psel=0
// SETUP  | psel=1, penable=0 for one cycle with address/data driven
// ACCESS | psel=1, penable=1; waiting for pready or timeout
module apb_master #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input logic          pclk,
  input logic          presetn,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t               state_q, state_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_to_q, rsp_to_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 cmd_ready;
  logic                 accept;

  // cmd_ready is combinational so a completing ACCESS can take the next
  // command in the same cycle and go straight back to SETUP.
  always_comb begin
    cmd_ready = presetn &&
                ((state_q == S_IDLE) || ((state_q == S_ACCESS) && bus.pready));
    accept    = bus.cmd_valid && cmd_ready;
  end

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // pready wins over the timeout when both land on the same cycle
        if (bus.pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          if (!pwrite_q) rsp_rdata_d = bus.prdata;
          if (accept) begin
            pwrite_d = bus.cmd_write;
            paddr_d  = bus.cmd_addr;
            pwdata_d = bus.cmd_wdata;
            state_d  = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TLIM))) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  logic pclk = 1'b0;
  logic presetn;

  apb_master_if #(.ADDRWIDTH(8), .DATAWIDTH(8)) bus();

  apb_master #(.DATAWIDTH(8), .ADDRWIDTH(8), .TIMEOUT(16)) u_dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.master)
  );

  always #5 pclk = ~pclk;

  // 256-byte memory slave with configurable wait states, error and hang
  logic [7:0] mem [256];
  int         wait_cfg;
  logic       hang;
  logic       slverr_cfg;
  int         wcnt;

  always_comb begin
    bus.pready  = bus.psel && bus.penable && !hang && (wcnt >= wait_cfg);
    bus.pslverr = slverr_cfg;
    bus.prdata  = mem[bus.paddr];
  end

  always @(posedge pclk) begin
    if (bus.psel && bus.penable && !bus.pready) wcnt <= wcnt + 1;
    else                                        wcnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      mem[bus.paddr] <= bus.pwdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic       slverr;
    logic       hang;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic       exp_to;
    int         exp_access;
  } vec_t;

  // Runs one isolated transfer; starts and ends just after a falling edge.
  task automatic run_vec(input vec_t v, input int idx);
    int n, lat, setup, acc, bad;
    hang          = v.hang;
    wait_cfg      = v.waits;
    slverr_cfg    = v.slverr;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge pclk); n++; end
    check($sformatf("v%0d_accept", idx), int'(n < 50), 1);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    lat = 1; setup = 0; acc = 0; bad = 0; n = 0;
    while (!bus.rsp_valid && n < 100) begin
      if (bus.psel && !bus.penable) setup++;
      if (bus.psel && bus.penable)  acc++;
      if (bus.psel && (bus.paddr != v.addr || bus.pwrite != v.write ||
                       (v.write && bus.pwdata != v.wdata))) bad++;
      lat++;
      @(negedge pclk);
      n++;
    end
    check($sformatf("v%0d_rsp_seen", idx), int'(n < 100), 1);
    check($sformatf("v%0d_rdata", idx), int'(bus.rsp_rdata), int'(v.exp_rdata));
    check($sformatf("v%0d_err", idx), int'(bus.rsp_err), int'(v.exp_err));
    check($sformatf("v%0d_timeout", idx), int'(bus.rsp_timeout), int'(v.exp_to));
    check($sformatf("v%0d_setup_cycles", idx), setup, 1);
    check($sformatf("v%0d_access_cycles", idx), acc, v.exp_access);
    check($sformatf("v%0d_addr_stable", idx), bad, 0);
    check($sformatf("v%0d_latency", idx), lat, 2 + v.exp_access);
    check($sformatf("v%0d_psel_idle", idx), int'(bus.psel), 0);
    @(negedge pclk);
    check($sformatf("v%0d_rsp_pulse", idx), int'(bus.rsp_valid), 0);
  endtask

  vec_t vecs [8];

  initial begin
    logic [4:0] e_psel, e_pen, e_rsp;
    int quiet;

    //         wr    addr   wdata  wt  err   hang  rdata  err   to   acc
    vecs[0] = '{1'b1, 8'h10, 8'hA5, 1,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 1,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 2};
    vecs[2] = '{1'b1, 8'hFF, 8'h5A, 0,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 0,  1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1};
    vecs[4] = '{1'b0, 8'h10, 8'h00, 0,  1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 16};
    vecs[5] = '{1'b0, 8'h10, 8'h00, 15, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 16};
    vecs[6] = '{1'b1, 8'h44, 8'h99, 3,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 4};
    vecs[7] = '{1'b0, 8'h44, 8'h00, 0,  1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1};

    presetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    wait_cfg      = 0;
    hang          = 1'b0;
    slverr_cfg    = 1'b0;

    // reset state
    @(negedge pclk);
    @(negedge pclk);
    check("rst_cmd_ready", int'(bus.cmd_ready), 0);
    check("rst_psel", int'(bus.psel), 0);
    check("rst_penable", int'(bus.penable), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rsp_err", int'(bus.rsp_err), 0);
    check("rst_rsp_timeout", int'(bus.rsp_timeout), 0);
    check("rst_paddr", int'(bus.paddr), 0);
    check("rst_pwdata", int'(bus.pwdata), 0);
    check("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
    presetn = 1'b1;
    #1;
    check("idle_cmd_ready", int'(bus.cmd_ready), 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // back-to-back: write 0x20=0x3C then read 0x20, cmd_valid held high
    wait_cfg      = 0;
    hang          = 1'b0;
    slverr_cfg    = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h20;
    bus.cmd_wdata = 8'h3C;
    e_psel = 5'b01111;
    e_pen  = 5'b01010;
    e_rsp  = 5'b10100;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check($sformatf("b2b_psel_c%0d", i), int'(bus.psel), int'(e_psel[i]));
      check($sformatf("b2b_penable_c%0d", i), int'(bus.penable), int'(e_pen[i]));
      check($sformatf("b2b_rsp_valid_c%0d", i), int'(bus.rsp_valid), int'(e_rsp[i]));
      if (i == 0) begin
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = 8'h00;
      end
      if (i == 1) check("b2b_cmd_ready_access", int'(bus.cmd_ready), 1);
      if (i == 2) begin
        check("b2b_wr_err", int'(bus.rsp_err), 0);
        check("b2b_rd_paddr", int'(bus.paddr), 8'h20);
        check("b2b_rd_pwrite", int'(bus.pwrite), 0);
        bus.cmd_valid = 1'b0;
      end
      if (i == 4) check("b2b_rd_rdata", int'(bus.rsp_rdata), 8'h3C);
    end

    // reset mid-ACCESS, 3 wait states in
    @(negedge pclk);
    hang          = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h10;
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    @(negedge pclk);
    check("mid_in_access", int'(bus.psel && bus.penable), 1);
    presetn = 1'b0;
    #1;
    check("mid_rst_cmd_ready", int'(bus.cmd_ready), 0);
    @(negedge pclk);
    check("mid_rst_psel", int'(bus.psel), 0);
    check("mid_rst_penable", int'(bus.penable), 0);
    check("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("mid_rst_paddr", int'(bus.paddr), 0);
    presetn = 1'b1;
    hang    = 1'b0;
    #1;
    check("mid_post_cmd_ready", int'(bus.cmd_ready), 1);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid) quiet++;
    end
    check("mid_no_rsp", quiet, 0);

    run_vec('{1'b1, 8'h55, 8'h77, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1}, 8);
    run_vec('{1'b0, 8'h55, 8'h00, 2, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 3}, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
